sum_display_mux: RTL
====================

SUM_DISPLAY_MUX -- requirements
Module: sum_display_mux

Interface
REQ-001: Parameter REFRESH_DIV, default 50000, is the number of clk cycles each digit is displayed; the legal minimum is 2.
REQ-002: clk  input  1  is the single clock; all logic SHALL be rising-edge triggered.
REQ-003: rst_n  input  1  is the synchronous, active-low reset, sampled on the clk rising edge.
REQ-004: sum_in  input  3  is the adder sum bits S[2:0].
REQ-005: cout_in  input  1  is the adder carry-out; {cout_in,sum_in} forms an unsigned value from 0 to 15.
REQ-006: load  input  1  is a capture request, sampled on every clk edge.
REQ-007: ack  output  1  is the capture acknowledge.
REQ-008: seg  output  7  is {g,f,e,d,c,b,a}, active-low, common-anode.
REQ-009: an  output  2  is the digit anodes, active-low: an[0] is units and an[1] is tens.
REQ-010: dp  output  1  is the decimal point, active-low.

Function
REQ-011: When load=1 at an edge, the block SHALL register val <= {cout_in,sum_in}.
REQ-012: ack SHALL be 1 in the cycle after every edge that captured; with load held high, ack stays high and val tracks the inputs every cycle.
REQ-013: One cycle after val updates, the block SHALL register tens = (val>=10) and units = val-10*tens; all arithmetic is 4-bit unsigned and no other values are possible.
REQ-014: The refresh counter SHALL count 0..REFRESH_DIV-1 and then wrap to 0; at each wrap, digit select sel toggles between two states, UNITS (sel=0) and TENS (sel=1).
REQ-015: In state UNITS, the registered outputs SHALL be an=2'b10 and seg=glyph(units).
REQ-016: In state TENS, the registered outputs SHALL be an=2'b01 and seg=glyph(tens).
REQ-017: seg and an SHALL change only together, on the edge after a sel change or a digit-register change; they never glitch independently.
REQ-018: The glyph encodings SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-019: dp SHALL be constant 1 (off).
REQ-020: A capture SHALL NOT reset the refresh counter or sel; the new digits appear in whichever slot is current.
REQ-021: Latency SHALL be as follows: load at edge N causes ack at N+1, digit registers updated at N+2, and seg reflecting the new value from edge N+3 in the current slot.

Reset
REQ-022: While rst_n=0 at an edge, the block SHALL set val=0, tens=0, units=0, counter=0, sel=UNITS, an=2'b10, seg=1000000, ack=0, dp=1.
REQ-023: load SHALL be ignored on any edge where rst_n=0.
REQ-024: Reset asserted mid-display SHALL take effect on the next edge, regardless of counter position.
REQ-025: After rst_n rises, the counter SHALL restart from 0 in state UNITS.

Configuration
REQ-026: With macro LEADING_ZERO_BLANK_EN defined, in state TENS with tens=0 the block SHALL drive seg=1111111 while an stays 2'b01.
REQ-027: Without LEADING_ZERO_BLANK_EN defined, tens=0 SHALL display glyph 0 (1000000); all other behaviour is identical in both builds.

Verification (REFRESH_DIV=4)
REQ-028: Bench SHALL cover reset: rst_n=0 for 3 cycles with load=1 and inputs=1111 -> an=10, seg=1000000, ack=0, dp=1, and val stays 0.
REQ-029: Bench SHALL cover a single capture: cout_in=1, sum_in=101, 1-cycle load -> ack high exactly 1 cycle at N+1; UNITS slot seg=0110000 (3) and TENS slot seg=1111001 (1).
REQ-030: Bench SHALL cover the refresh wrap: no load activity -> an alternates 10/01 every exactly 4 cycles, with seg and an always switching on the same edge.
REQ-031: Bench SHALL cover leading-zero handling: value 9 (cout_in=0, sum_in=... impossible, use 0111=7) -> UNITS seg=1111000; TENS seg=1111111 with LEADING_ZERO_BLANK_EN and 1000000 without.
REQ-032: Bench SHALL cover continuous load: load held high while inputs step 0000->1010->1111 -> ack stays 1, and the final display is units 5 (0010010) and tens 1.
REQ-033: Bench SHALL cover reset mid-operation: rst_n pulsed low during the TENS slot after a capture of 1100 -> next edge gives reset values, and after release UNITS is shown with digit 0 for 4 cycles.

Source files
------------

// File: rtl/sum_display_mux.sv
// sum_display_mux: captures a 4-bit adder result {cout_in,sum_in}, splits it
// into tens/units digits and time-multiplexes them onto a two-digit,
// common-anode seven-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the tens digit when it is 0.
module sum_display_mux #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sum_in,
  input  logic       cout_in,
  input  logic       load,
  output logic       ack,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] AN_UNITS  = 2'b10;
  localparam logic [1:0] AN_TENS   = 2'b01;

  typedef enum logic {UNITS = 1'b0, TENS = 1'b1} sel_t;

  // Seven-segment glyph lookup, {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  logic [3:0]    val_q, val_d;
  logic          ack_q, ack_d;
  logic          tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [CW-1:0] cnt_q, cnt_d;
  sel_t          sel_q, sel_d;
  logic [1:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  // Capture path: latch the adder result on load and acknowledge next cycle.
  always_comb begin
    val_d = val_q;
    ack_d = 1'b0;
    if (load) begin
      val_d = {cout_in, sum_in};
      ack_d = 1'b1;
    end else begin
      val_d = val_q;
      ack_d = 1'b0;
    end
  end

  // Digit split: value is at most 15, so tens is a single bit.
  always_comb begin
    tens_d  = (val_q >= 4'd10);
    units_d = val_q - (tens_d ? 4'd10 : 4'd0);
  end

  // Refresh counter and digit-slot select; a capture never disturbs these.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      sel_d = (sel_q == UNITS) ? TENS : UNITS;
    end else begin
      cnt_d = cnt_q + 1'b1;
      sel_d = sel_q;
    end
  end

  // Display drive: anode and segments are computed together so they
  // are registered on the same edge.
  always_comb begin
    an_d  = AN_UNITS;
    seg_d = SEG_ZERO;
    case (sel_q)
      UNITS: begin
        an_d  = AN_UNITS;
        seg_d = glyph(units_q);
      end
      TENS: begin
        an_d = AN_TENS;
`ifdef LEADING_ZERO_BLANK_EN
        if (!tens_q) begin
          seg_d = SEG_BLANK;
        end else begin
          seg_d = glyph({3'b000, tens_q});
        end
`else
        seg_d = glyph({3'b000, tens_q});
`endif
      end
      default: begin
        an_d  = AN_UNITS;
        seg_d = SEG_ZERO;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q   <= 4'd0;
      ack_q   <= 1'b0;
      tens_q  <= 1'b0;
      units_q <= 4'd0;
      cnt_q   <= '0;
      sel_q   <= UNITS;
      an_q    <= AN_UNITS;
      seg_q   <= SEG_ZERO;
    end else begin
      val_q   <= val_d;
      ack_q   <= ack_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign ack = ack_q;
  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule
